// File: rtl/host_jtag_pkg.sv
// rtl/host_jtag_pkg.sv - shared constants, byte-count helper and packer state type
//
// Purpose : common definitions for the JTAG->host response return path.
// Contents: JTAG_RESP_WIDTH_DEF  default response word width (3-bit ACK + 32-bit data)
//           resp_nbytes()        bytes needed to carry a response word
//           packer_state_e       state type of jtag_resp_host_packer
package host_jtag_pkg;

    localparam int JTAG_RESP_WIDTH_DEF = 35;

    function automatic int resp_nbytes(input int width);
        return (width + 7) / 8;
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_POP  = 3'd1,
        ST_LOAD = 3'd2,
        ST_SEND = 3'd3,
        ST_CSUM = 3'd4
    } packer_state_e;

endpackage

// File: rtl/jtag_resp_host_packer.sv
// rtl/jtag_resp_host_packer.sv - serializes JTAG response words into a little-endian host byte stream
//
// Purpose : pops one response word at a time from the JTAG PHY response FIFO
//           and writes it LSB byte first into the host TX byte FIFO.
// Ports   : CLK, RESETn (async, active-low)
//           JTAG_RDDATA / JTAG_RDEMPTY / JTAG_RDEN   response FIFO read port
//           HOST_WRDATA / HOST_WREN / HOST_WRFULL    host byte FIFO write port
//           BUSY      high while a response is in flight
//           RESP_CNT  completed responses since reset (wraps)
// Config  : define JTAG_RESP_HOST_CSUM_EN to append an XOR checksum byte
//           after the data bytes of every response.
module jtag_resp_host_packer
    import host_jtag_pkg::*;
#(
    parameter int JTAG_RESP_WIDTH = JTAG_RESP_WIDTH_DEF
) (
    input  logic                       CLK,
    input  logic                       RESETn,
    input  logic [JTAG_RESP_WIDTH-1:0] JTAG_RDDATA,
    input  logic                       JTAG_RDEMPTY,
    output logic                       JTAG_RDEN,
    output logic [7:0]                 HOST_WRDATA,
    output logic                       HOST_WREN,
    input  logic                       HOST_WRFULL,
    output logic                       BUSY,
    output logic [15:0]                RESP_CNT
);

    localparam int NBYTES = resp_nbytes(JTAG_RESP_WIDTH);
    localparam int SW     = NBYTES * 8;
    localparam int IW     = $clog2(NBYTES + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

    packer_state_e  state;
    logic [SW-1:0]  shreg;
    logic [IW-1:0]  idx;
    logic [15:0]    resp_cnt;
    logic           send_ok;
    logic           csum_ok;
`ifdef JTAG_RESP_HOST_CSUM_EN
    logic [7:0]     csum;
`endif

    // Write strobes are qualified by HOST_WRFULL in the same cycle so a
    // write can never be presented against a full host FIFO.
    always_comb begin
        send_ok = (state == ST_SEND) && !HOST_WRFULL;
`ifdef JTAG_RESP_HOST_CSUM_EN
        csum_ok = (state == ST_CSUM) && !HOST_WRFULL;
`else
        csum_ok = 1'b0;
`endif
    end

    // The outgoing byte always sits in shreg[7:0]; in checksum mode the
    // checksum is parked there after the last data byte leaves.
    assign HOST_WRDATA = shreg[7:0];
    assign HOST_WREN   = send_ok | csum_ok;
    assign JTAG_RDEN   = RESETn && (state == ST_IDLE) && !JTAG_RDEMPTY;
    assign BUSY        = (state != ST_IDLE);
    assign RESP_CNT    = resp_cnt;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state    <= ST_IDLE;
            shreg    <= '0;
            idx      <= '0;
            resp_cnt <= '0;
`ifdef JTAG_RESP_HOST_CSUM_EN
            csum     <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (JTAG_RDEN) begin
                        state <= ST_POP;
                    end
                end
                ST_POP: begin
                    state <= ST_LOAD;
                end
                ST_LOAD: begin
                    // Zero-extension keeps the pad bits of the top byte clear.
                    shreg <= SW'(JTAG_RDDATA);
                    idx   <= '0;
`ifdef JTAG_RESP_HOST_CSUM_EN
                    csum  <= '0;
`endif
                    state <= ST_SEND;
                end
                ST_SEND: begin
                    if (send_ok) begin
                        shreg <= shreg >> 8;
                        idx   <= idx + IW'(1);
`ifdef JTAG_RESP_HOST_CSUM_EN
                        csum  <= csum ^ shreg[7:0];
                        if (idx == LAST_IDX) begin
                            shreg <= SW'(csum ^ shreg[7:0]);
                            state <= ST_CSUM;
                        end
`else
                        if (idx == LAST_IDX) begin
                            resp_cnt <= resp_cnt + 16'd1;
                            state    <= ST_IDLE;
                        end
`endif
                    end
                end
`ifdef JTAG_RESP_HOST_CSUM_EN
                ST_CSUM: begin
                    if (csum_ok) begin
                        shreg    <= '0;
                        resp_cnt <= resp_cnt + 16'd1;
                        state    <= ST_IDLE;
                    end
                end
`endif
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_resp_host_packer.sv
// tb/tb_jtag_resp_host_packer.sv - self-checking bench for jtag_resp_host_packer
module tb_jtag_resp_host_packer;

    localparam int W  = 35;
    localparam int NB = (W + 7) / 8;
`ifdef JTAG_RESP_HOST_CSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif
    localparam int NBT = NB + CS;

    logic          CLK = 1'b0;
    logic          RESETn = 1'b0;
    logic [W-1:0]  JTAG_RDDATA = '0;
    logic          JTAG_RDEMPTY = 1'b1;
    logic          JTAG_RDEN;
    logic [7:0]    HOST_WRDATA;
    logic          HOST_WREN;
    logic          HOST_WRFULL = 1'b0;
    logic          BUSY;
    logic [15:0]   RESP_CNT;

    jtag_resp_host_packer dut (
        .CLK          (CLK),
        .RESETn       (RESETn),
        .JTAG_RDDATA  (JTAG_RDDATA),
        .JTAG_RDEMPTY (JTAG_RDEMPTY),
        .JTAG_RDEN    (JTAG_RDEN),
        .HOST_WRDATA  (HOST_WRDATA),
        .HOST_WREN    (HOST_WREN),
        .HOST_WRFULL  (HOST_WRFULL),
        .BUSY         (BUSY),
        .RESP_CNT     (RESP_CNT)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int n_wr_full = 0;
    int n_rd_empty = 0;
    int n_busy = 0;
    int exp_cnt = 0;

    logic [W-1:0] fifo_q[$];
    logic [7:0]   exp_q[$];
    logic [7:0]   got_q[$];
    int           wr_cyc[$];
    int           rden_cyc[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    // Response FIFO model: data shows up the cycle after the pop.
    always @(posedge CLK) begin
        if (JTAG_RDEN && fifo_q.size() > 0) begin
            JTAG_RDDATA  <= fifo_q.pop_front();
            JTAG_RDEMPTY <= (fifo_q.size() == 0);
        end
    end

    // Host FIFO side observer, sampling mid-cycle.
    always begin
        @(negedge CLK);
        #2;
        if (RESETn) begin
            if (HOST_WREN) begin
                got_q.push_back(HOST_WRDATA);
                wr_cyc.push_back(cyc);
                if (HOST_WRFULL) n_wr_full++;
            end
            if (JTAG_RDEN) begin
                rden_cyc.push_back(cyc);
                if (JTAG_RDEMPTY) n_rd_empty++;
            end
            if (BUSY) n_busy++;
        end
    end

    // Reference: a response is its bytes least significant first, padded
    // with zeros, optionally followed by the XOR of those bytes.
    task automatic push_word(input logic [W-1:0] w);
        logic [63:0] v;
        logic [7:0]  b;
        logic [7:0]  x;
        v = 64'(w);
        x = 8'h00;
        for (int i = 0; i < NB; i++) begin
            b = 8'((v >> (8 * i)) & 64'hFF);
            exp_q.push_back(b);
            x = x ^ b;
        end
        if (CS != 0) exp_q.push_back(x);
        fifo_q.push_back(w);
        JTAG_RDEMPTY = 1'b0;
    endtask

    task automatic clear_obs();
        got_q.delete();
        exp_q.delete();
        wr_cyc.delete();
        rden_cyc.delete();
        n_busy = 0;
    endtask

    task automatic wait_bytes(input string tag, input int n, input int budget);
        int k;
        k = 0;
        while (got_q.size() < n && k < budget) begin
            @(negedge CLK);
            k++;
        end
        if (got_q.size() < n) check({tag, "_timeout"}, 64'(got_q.size()), 64'(n));
    endtask

    task automatic finish_phase(input string tag, input int words);
        wait_bytes(tag, exp_q.size(), 20000);
        repeat (3) @(negedge CLK);
        check({tag, "_len"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
        exp_cnt = (exp_cnt + words) % 65536;
        check({tag, "_cnt"}, 64'(RESP_CNT), 64'(exp_cnt));
        check({tag, "_idle"}, 64'(BUSY), 64'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rden"},  64'(JTAG_RDEN),   64'd0);
        check({tag, "_wren"},  64'(HOST_WREN),   64'd0);
        check({tag, "_wdata"}, 64'(HOST_WRDATA), 64'd0);
        check({tag, "_busy"},  64'(BUSY),        64'd0);
        check({tag, "_cnt"},   64'(RESP_CNT),    64'd0);
    endtask

    initial begin
        logic [W-1:0] ref_word;
        logic [63:0]  r;
        int           rel;
        int           left;
        ref_word = 35'h4_1234_5678;

        // reset state
        repeat (2) @(negedge CLK);
        #1;
        check_reset_vals("rst");
        @(negedge CLK);
        RESETn = 1'b1;

        // empty FIFO: nothing moves
        clear_obs();
        repeat (20) @(negedge CLK);
        check("empty_rden", 64'(rden_cyc.size()), 64'd0);
        check("empty_wren", 64'(got_q.size()), 64'd0);
        check("empty_busy", 64'(n_busy), 64'd0);

        // single response, host never full
        clear_obs();
        push_word(ref_word);
        finish_phase("single", 1);
        check("single_b0", 64'(got_q[0]), 64'h78);
        check("single_b1", 64'(got_q[1]), 64'h56);
        check("single_b2", 64'(got_q[2]), 64'h34);
        check("single_b3", 64'(got_q[3]), 64'h12);
        check("single_b4", 64'(got_q[4]), 64'h04);
        check("single_lat", 64'(wr_cyc[0] - rden_cyc[0]), 64'd3);
        check("single_burst", 64'(wr_cyc[NBT-1] - wr_cyc[0]), 64'(NBT - 1));

        // host full for 4 cycles after the 2nd byte
        clear_obs();
        push_word(ref_word);
        wait_bytes("bp", 2, 100);
        HOST_WRFULL = 1'b1;
        repeat (4) @(negedge CLK);
        HOST_WRFULL = 1'b0;
        rel = cyc;
        finish_phase("bp", 1);
        check("bp_resume", 64'(wr_cyc[2]), 64'(rel));
        check("bp_gap", 64'(wr_cyc[2] - wr_cyc[1]), 64'd5);

        // three queued responses back to back
        clear_obs();
        for (int i = 0; i < 3; i++) begin
            r = {$urandom(), $urandom()};
            push_word(r[W-1:0]);
        end
        finish_phase("q3", 3);
        check("q3_pops", 64'(rden_cyc.size()), 64'd3);
        for (int i = 1; i < 3 && i < rden_cyc.size(); i++)
            check($sformatf("q3_space%0d", i), 64'(rden_cyc[i] - rden_cyc[i-1]), 64'(NB + 3 + CS));

        // randomized traffic and backpressure
        clear_obs();
        left = 40;
        while (left > 0) begin
            @(negedge CLK);
            HOST_WRFULL = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) == 0) begin
                r = {$urandom(), $urandom()};
                push_word(r[W-1:0]);
                left--;
            end
        end
        @(negedge CLK);
        HOST_WRFULL = 1'b0;
        finish_phase("rand", 40);

        // reset in the middle of a response
        clear_obs();
        push_word(35'h7_DEAD_BEEF);
        wait_bytes("mrst", 2, 100);
        #1 RESETn = 1'b0;
        #1;
        check_reset_vals("mrst");
        repeat (2) @(negedge CLK);
        RESETn = 1'b1;
        exp_cnt = 0;
        clear_obs();
        repeat (15) @(negedge CLK);
        check("mrst_residual", 64'(got_q.size()), 64'd0);
        push_word(ref_word);
        finish_phase("mrst_next", 1);

        // counter wrap
        clear_obs();
        @(negedge CLK);
        force dut.resp_cnt = 16'hFFFF;
        #1 release dut.resp_cnt;
        #1 check("wrap_pre", 64'(RESP_CNT), 64'hFFFF);
        exp_cnt = 65535;
        push_word(ref_word);
        finish_phase("wrap", 1);

        check("no_write_when_full", 64'(n_wr_full), 64'd0);
        check("no_pop_when_empty", 64'(n_rd_empty), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
